font_rom_arbiter: RTL and testbench

//  Shares the single font ROM among N text painters (score, state, future

---
 rtl/font_rom_arbiter.sv | 76 +++++++
 tb/tb_font_rom_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/font_rom_arbiter.sv
// rtl/font_rom_arbiter.sv - round-robin share of one font ROM among N_REQ glyph-row readers
module font_rom_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         font_word,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [N_REQ*DATA_W-1:0]   rd_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N_REQ - 1);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx;
  logic             found;

  logic             pipe_v  [ROM_LAT];
  logic [PTR_W-1:0] pipe_id [ROM_LAT];

  // Wrap compares against N_REQ-1 so non-power-of-2 counts never reach an unused index.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == LAST) ? '0 : idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt      <= '0;
      rom_addr <= '0;
      rr_ptr   <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
      for (int j = 0; j < ROM_LAT; j++) begin
        pipe_v[j]  <= 1'b0;
        pipe_id[j] <= '0;
      end
    end else begin
      gnt <= found ? (N_REQ'(1) << win) : '0;
      if (found) begin
        rom_addr <= req_addr[int'(win)*ADDR_W +: ADDR_W];
        rr_ptr   <= (win == LAST) ? '0 : win + PTR_W'(1);
      end

      // Stage 0 mirrors gnt; the last stage lines up with the ROM word for that grant.
      pipe_v[0]  <= found;
      pipe_id[0] <= win;
      for (int j = 1; j < ROM_LAT; j++) begin
        pipe_v[j]  <= pipe_v[j-1];
        pipe_id[j] <= pipe_id[j-1];
      end

      rd_valid <= pipe_v[ROM_LAT-1] ? (N_REQ'(1) << pipe_id[ROM_LAT-1]) : '0;
      if (pipe_v[ROM_LAT-1])
        rd_data[int'(pipe_id[ROM_LAT-1])*DATA_W +: DATA_W] <= font_word;
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb/tb_font_rom_arbiter.sv - directed checks of font_rom_arbiter at (N=2,LAT=1) and (N=3,LAT=3)
module tb_font_rom_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance A: N_REQ=2, ROM_LAT=1
  logic [1:0]  req_a = '0;
  logic [21:0] addr_a = '0;
  logic [1:0]  gnt_a;
  logic [10:0] rom_addr_a;
  logic [7:0]  fw_a;
  logic [1:0]  rdv_a;
  logic [15:0] rdd_a;
  logic        fw_const_en = 1'b0;
  logic [7:0]  fw_const = '0;

  assign fw_a = fw_const_en ? fw_const : rom_addr_a[7:0];

  font_rom_arbiter #(.N_REQ(2), .ADDR_W(11), .DATA_W(8), .ROM_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .req_addr(addr_a), .gnt(gnt_a),
    .rom_addr(rom_addr_a), .font_word(fw_a), .rd_valid(rdv_a), .rd_data(rdd_a)
  );

  // instance B: N_REQ=3, ROM_LAT=3, stub ROM delays the address two more edges
  logic [2:0]  req_b = '0;
  logic [32:0] addr_b = '0;
  logic [2:0]  gnt_b;
  logic [10:0] rom_addr_b;
  logic [10:0] d1_b, d2_b;
  logic [7:0]  fw_b;
  logic [2:0]  rdv_b;
  logic [23:0] rdd_b;

  always @(posedge clk) begin
    d1_b <= rom_addr_b;
    d2_b <= d1_b;
  end
  assign fw_b = d2_b[7:0];

  font_rom_arbiter #(.N_REQ(3), .ADDR_W(11), .DATA_W(8), .ROM_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .req_addr(addr_b), .gnt(gnt_b),
    .rom_addr(rom_addr_b), .font_word(fw_b), .rd_valid(rdv_b), .rd_data(rdd_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [10:0] a3 [4];
  logic [2:0]  exp_gnt_b [8];
  logic [2:0]  exp_rdv_b [8];
  logic [10:0] exp_ra_b  [8];

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("rst_gnt", gnt_a, 0);
    check("rst_rdv", rdv_a, 0);
    check("rst_rom_addr", rom_addr_a, 0);
    check("rst_rdd", rdd_a, 0);

    // 1: single read, constant ROM word
    req_a = 2'b01; addr_a[10:0] = 11'h4A3; fw_const_en = 1'b1; fw_const = 8'h3C;
    tick();
    check("t1_gnt", gnt_a, 2'b01);
    check("t1_rom_addr", rom_addr_a, 11'h4A3);
    check("t1_rdv_early", rdv_a, 0);
    req_a = 2'b00;
    tick();
    check("t1_rdv", rdv_a, 2'b01);
    check("t1_rdd0", rdd_a[7:0], 8'h3C);
    check("t1_gnt_idle", gnt_a, 0);
    fw_const_en = 1'b0;

    // 2: both requesting alternate, starting from index 0 after reset
    reset = 1'b1; tick(); reset = 1'b0;
    addr_a = {11'h222, 11'h111};
    req_a = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t2_gnt", gnt_a, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("t2_rom_addr", rom_addr_a, (k % 2 == 0) ? 11'h111 : 11'h222);
      check("t2_rdv", rdv_a, (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10));
    end
    req_a = 2'b00;
    tick();
    check("t2_rdv_last", rdv_a, 2'b10);
    check("t2_rdd", rdd_a, 16'h2211);

    // 3: lone requester 1 granted every cycle, slice 0 untouched
    a3[0] = 11'h300; a3[1] = 11'h315; a3[2] = 11'h32A; a3[3] = 11'h33F;
    req_a = 2'b10;
    for (int k = 0; k < 4; k++) begin
      addr_a[21:11] = a3[k];
      tick();
      check("t3_gnt", gnt_a, 2'b10);
      check("t3_rom_addr", rom_addr_a, a3[k]);
      if (k > 0) begin
        check("t3_rdv", rdv_a, 2'b10);
        check("t3_rdd1", rdd_a[15:8], a3[k-1][7:0]);
        check("t3_rdd0", rdd_a[7:0], 8'h11);
      end
    end
    req_a = 2'b00;
    tick();
    check("t3_rdv_last", rdv_a, 2'b10);
    check("t3_rdd_last", rdd_a, 16'h3F11);

    // 4: reset between grant and return discards the read
    req_a = 2'b01; addr_a[10:0] = 11'h155;
    tick();
    check("t4_gnt", gnt_a, 2'b01);
    req_a = 2'b00;
    reset = 1'b1;
    #1;
    check("t4_async_gnt", gnt_a, 0);
    check("t4_async_rdd", rdd_a, 0);
    tick();
    reset = 1'b0;
    check("t4_rdv_a", rdv_a, 0);
    tick();
    check("t4_rdv_b", rdv_a, 0);
    req_a = 2'b11;
    tick();
    check("t4_first_gnt", gnt_a, 2'b01);
    req_a = 2'b00;
    tick();
    check("t4_rdv_after", rdv_a, 2'b01);
    check("t4_rdd", rdd_a, 16'h0055);

    // 6: glitch on req[0] between edges is never granted; a sampled one is
    addr_a = {11'h2F0, 11'h1E7};
    req_a = 2'b10;
    tick();
    check("t6_gnt1", gnt_a, 2'b10);
    req_a = 2'b11; #2; req_a = 2'b10;
    tick();
    check("t6_no_gnt0", gnt_a, 2'b10);
    check("t6_rdv1", rdv_a, 2'b10);
    req_a = 2'b11;
    tick();
    check("t6_turn_gnt0", gnt_a, 2'b01);
    req_a = 2'b10;
    tick();
    check("t6_back_gnt1", gnt_a, 2'b10);
    check("t6_rdv0", rdv_a, 2'b01);
    req_a = 2'b00;
    tick();
    check("t6_rdv_tail", rdv_a, 2'b10);
    check("t6_rdd", rdd_a, 16'hF0E7);
    tick();
    check("t6_idle_rdv", rdv_a, 0);

    // 5: three requesters, ROM_LAT=3
    check("t5_rst_rdd", rdd_b, 0);
    addr_b = {11'h0C3, 11'h0B2, 11'h0A1};
    exp_gnt_b = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000};
    exp_rdv_b = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
    exp_ra_b  = '{11'h000, 11'h0A1, 11'h0B2, 11'h0C3, 11'h0A1, 11'h0A1, 11'h0A1, 11'h0A1};
    req_b = 3'b111;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check("t5_gnt", gnt_b, exp_gnt_b[c]);
      check("t5_rdv", rdv_b, exp_rdv_b[c]);
      check("t5_rom_addr", rom_addr_b, exp_ra_b[c]);
      if (c == 4) req_b = 3'b000;
    end
    check("t5_rdd", rdd_b, 24'hC3B2A1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
